// File: rtl/tile_rom_arbiter.sv
// Round-robin request/acknowledge arbiter sharing one tile character ROM among NREQ fetchers.
// Define TILE_ROM_ARB_STATS_EN to add per-requester worst-case wait statistics (stall_max).
module tile_rom_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 14,
  parameter int DW   = 24,
  parameter int LAT  = 1
) (
  input  logic                 VCLKx8,
  input  logic                 RESET_N,
  input  logic                 HOLD,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_ad,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ*DW-1:0]   rdata,
  output logic [AW-1:0]        rom_ad,
  input  logic [DW-1:0]        rom_dt,
  output logic                 busy
`ifdef TILE_ROM_ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0]    stall_max
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nx;
  logic [PW-1:0]   win;
  logic [CW-1:0]   cand;
  logic            grant;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] pend_nx;
  logic [LAT-1:0]  vld;
  logic [LAT-1:0]  vld_nx;
  logic [PW-1:0]   pid [LAT];
  logic            done;
  logic [PW-1:0]   did;

  // Winner is the first eligible index at or after ptr, wrapping at NREQ.
  // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    elig  = req & ~pend & ~ack;
    grant = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = CW'(ptr) + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!grant && elig[cand[PW-1:0]]) begin
        grant = 1'b1;
        win   = cand[PW-1:0];
      end
    end
    if (HOLD) grant = 1'b0;
  end

  assign ptr_nx = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign done   = vld[LAT-1];
  assign did    = pid[LAT-1];

  always_comb begin
    vld_nx    = '0;
    vld_nx[0] = grant;
    for (int i = 1; i < LAT; i++) vld_nx[i] = vld[i-1];
    pend_nx = pend;
    if (done)  pend_nx[did] = 1'b0;
    if (grant) pend_nx[win] = 1'b1;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr    <= '0;
      pend   <= '0;
      vld    <= '0;
      busy   <= 1'b0;
      rom_ad <= '0;
      ack    <= '0;
      rdata  <= '0;
    end else begin
      vld  <= vld_nx;
      busy <= |vld_nx;
      pend <= pend_nx;
      ack  <= '0;
      if (grant) begin
        rom_ad <= req_ad[win*AW +: AW];
        ptr    <= ptr_nx;
      end
      if (done) begin
        ack[did]             <= 1'b1;
        rdata[did*DW +: DW]  <= rom_dt;
      end
    end
  end

  // NOTE: the id pipeline is left unreset; its entries are ignored unless the matching valid bit is set.
  always_ff @(posedge VCLKx8) begin
    pid[0] <= win;
    for (int i = 1; i < LAT; i++) pid[i] <= pid[i-1];
  end

`ifdef TILE_ROM_ARB_STATS_EN
  logic [7:0] wait_cnt [NREQ];
  logic [7:0] wait_max [NREQ];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // A requester waits while eligible but not granted; held-off cycles count too.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < NREQ; k++) begin
        wait_cnt[k] <= '0;
        wait_max[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (grant && win == PW'(k)) begin
          wait_cnt[k] <= '0;
        end else if (elig[k]) begin
          wait_cnt[k] <= sat_inc(wait_cnt[k]);
          if (sat_inc(wait_cnt[k]) > wait_max[k]) wait_max[k] <= sat_inc(wait_cnt[k]);
        end
      end
    end
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_stall
    assign stall_max[k*8 +: 8] = wait_max[k];
  end
`endif

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Scoreboard bench for tile_rom_arbiter: two instances (LAT=1 and LAT=3) share stimulus,
// each with its own ROM model, transaction-level reference model and monitor.
module tb_tile_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  req = '0;
  logic [41:0] req_ad = '0;

  logic [2:0]  ack_w    [2];
  logic [71:0] rdata_w  [2];
  logic [13:0] rom_ad_w [2];
  logic [23:0] rom_dt_w [2];
  logic        busy_w   [2];
`ifdef TILE_ROM_ARB_STATS_EN
  logic [23:0] stall_w  [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int outstanding [2] = '{0, 0};

  typedef struct { int id; logic [13:0] ad; int due; } fl_t;
  typedef struct { int id; logic [23:0] d; } exp_t;

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(input logic [13:0] a);
    logic [23:0] t;
    t = {10'd0, a} - 24'h000123;
    return 24'hA5C3F0 ^ (t * 24'h00A3B1);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L  = (g == 0) ? 1 : 3;
    localparam int DI = (L > 1) ? L - 2 : 0;

    logic [13:0] dl [3];
    always @(posedge clk) begin
      dl[0] <= rom_ad_w[g];
      dl[1] <= dl[0];
      dl[2] <= dl[1];
    end
    assign rom_dt_w[g] = rom_f((L == 1) ? rom_ad_w[g] : dl[DI]);

    tile_rom_arbiter #(.NREQ(3), .AW(14), .DW(24), .LAT(L)) dut (
      .VCLKx8   (clk),
      .RESET_N  (rst_n),
      .HOLD     (hold),
      .req      (req),
      .req_ad   (req_ad),
      .ack      (ack_w[g]),
      .rdata    (rdata_w[g]),
      .rom_ad   (rom_ad_w[g]),
      .rom_dt   (rom_dt_w[g]),
      .busy     (busy_w[g])
`ifdef TILE_ROM_ARB_STATS_EN
      ,
      .stall_max(stall_w[g])
`endif
    );

    logic [2:0]  m_pend, m_ack;
    int          m_ptr;
    logic [13:0] m_rom_ad;
    logic [23:0] m_rdata [3];
    logic        m_busy;
    int          m_cnt [3];
    int          m_smax [3];
    int          ec;
    fl_t         fl [$];
    exp_t        exp_q [$];

    // Reference: reads are (id, address, due edge) records; completion after LAT edges.
    initial begin : model
      logic [2:0]  elig;
      int          w;
      logic [13:0] a;
      fl_t         f;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_pend = '0; m_ack = '0; m_ptr = 0; m_rom_ad = '0; m_busy = 1'b0; ec = 0;
          for (int k = 0; k < 3; k++) begin
            m_rdata[k] = '0; m_cnt[k] = 0; m_smax[k] = 0;
          end
          fl.delete();
          exp_q.delete();
          outstanding[g] = 0;
        end else begin
          ec++;
          elig = req & ~m_pend & ~m_ack;
          w = -1;
          if (!hold)
            for (int i = 0; i < 3; i++)
              if (w < 0 && elig[(m_ptr + i) % 3]) w = (m_ptr + i) % 3;
          for (int k = 0; k < 3; k++) begin
            if (w == k) m_cnt[k] = 0;
            else if (elig[k]) begin
              if (m_cnt[k] < 255) m_cnt[k]++;
              if (m_cnt[k] > m_smax[k]) m_smax[k] = m_cnt[k];
            end
          end
          m_ack = '0;
          while (fl.size() > 0 && fl[0].due == ec) begin
            f = fl.pop_front();
            m_ack[f.id]   = 1'b1;
            m_rdata[f.id] = rom_f(f.ad);
            m_pend[f.id]  = 1'b0;
          end
          if (w >= 0) begin
            a = req_ad[w*14 +: 14];
            m_pend[w] = 1'b1;
            m_ptr     = (w + 1) % 3;
            m_rom_ad  = a;
            fl.push_back('{w, a, ec + L});
            exp_q.push_back('{w, rom_f(a)});
          end
          m_busy = (fl.size() > 0);
          outstanding[g] = exp_q.size();
        end
      end
    end

    initial begin : monitor
      exp_t e;
      forever begin
        @(negedge clk);
        check($sformatf("L%0d ack", g), ack_w[g], m_ack);
        check($sformatf("L%0d rom_ad", g), rom_ad_w[g], m_rom_ad);
        check($sformatf("L%0d busy", g), busy_w[g], m_busy);
        check($sformatf("L%0d rdata", g), rdata_w[g], {m_rdata[2], m_rdata[1], m_rdata[0]});
`ifdef TILE_ROM_ARB_STATS_EN
        check($sformatf("L%0d stall_max", g), stall_w[g],
              {8'(m_smax[2]), 8'(m_smax[1]), 8'(m_smax[0])});
`endif
        if (ack_w[g] != '0) begin
          if (exp_q.size() == 0) begin
            check($sformatf("L%0d unexpected ack", g), ack_w[g], 0);
          end else begin
            e = exp_q.pop_front();
            outstanding[g] = exp_q.size();
            check($sformatf("L%0d ack id", g), ack_w[g], 3'b001 << e.id);
            check($sformatf("L%0d ack data", g), rdata_w[g][e.id*24 +: 24], e.d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    hold  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (outstanding[0] + outstanding[1]) != 0; i++) tick();
    check("drain outstanding", outstanding[0] + outstanding[1], 0);
  endtask

  initial begin : stim
    logic [2:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    do_reset();
    check("reset rom_ad", rom_ad_w[0], 14'h0);
    check("reset rdata", rdata_w[1], 72'h0);
    check("reset busy", busy_w[0], 1'b0);

    // Single request: address 0123 appears one edge later, ack one edge after that.
    req_ad[13:0] = 14'h0123;
    req = 3'b001;
    tick();
    check("single rom_ad", rom_ad_w[0], 14'h0123);
    check("single no early ack", ack_w[0], 3'b000);
    tick();
    check("single ack", ack_w[0], 3'b001);
    check("single rdata0", rdata_w[0][23:0], 24'hA5C3F0);
    req = '0;
    drain();

    // All three from reset: round-robin grants and acks on consecutive clocks.
    do_reset();
    req_ad = {14'h2222, 14'h1111, 14'h0AAA};
    req = 3'b111;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr ack %0d", i), ack_w[0], seq[i]);
    end
    req = '0;
    drain();

    // Lone requester held high: never acks on the other two ports.
    req_ad[27:14] = 14'h3456;
    req = 3'b010;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("lone no spurious ack", ack_w[0] & 3'b101, 3'b000);
    end
    req = '0;
    drain();

    // HOLD right after a grant to 0 while 1 waits.
    do_reset();
    req_ad = {14'h0000, 14'h0BBB, 14'h0AAA};
    req = 3'b001;
    tick();
    hold = 1'b1;
    req  = 3'b011;
    tick();
    check("hold ack0", ack_w[0], 3'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold busy", busy_w[0], 1'b0);
      check("hold no grant", rom_ad_w[0], 14'h0AAA);
    end
    hold = 1'b0;
    tick();
    check("hold release grant1", rom_ad_w[0], 14'h0BBB);
    req = '0;
    drain();

    // Reset in the middle of a LAT=3 read.
    do_reset();
    req_ad = {14'h1234, 14'h0555, 14'h0666};
    req = 3'b100;
    tick();
    check("inflight busy", busy_w[1], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst busy", busy_w[1], 1'b0);
    check("async rst ack", ack_w[1], 3'b000);
    check("async rst rdata", rdata_w[1], 72'h0);
    check("async rst rom_ad", rom_ad_w[1], 14'h0);
    req = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no ack after reset", ack_w[1], 3'b000);
    end
    req = 3'b111;
    tick();
    check("ptr0 after reset L0", rom_ad_w[0], 14'h0666);
    check("ptr0 after reset L1", rom_ad_w[1], 14'h0666);
    req = '0;
    drain();

`ifdef TILE_ROM_ARB_STATS_EN
    do_reset();
    req_ad = {14'h0100, 14'h0200, 14'h0300};
    req  = 3'b101;
    hold = 1'b1;
    repeat (10) tick();
    hold = 1'b0;
    repeat (2) tick();
    check("stall_max0 L0", stall_w[0][7:0], 8'd10);
    check("stall_max2 L0", stall_w[0][23:16], 8'd11);
    check("stall_max0 L1", stall_w[1][7:0], 8'd10);
    check("stall_max2 L1", stall_w[1][23:16], 8'd11);
    req = '0;
    drain();
`endif

    // Randomized traffic with HOLD bursts and address churn.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
        req_ad[k*14 +: 14] = 14'($urandom());
      end
      hold = ($urandom_range(0, 9) == 0);
      tick();
    end
    req  = '0;
    hold = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
